nac_mem_arb: RTL

NAC_MEM_ARB -- requirements
Module: nac_mem_arb

---
 rtl/nac_pkg.sv | 12 +
 rtl/nac_starve_cnt.sv | 33 +++
 rtl/nac_mem_arb.sv | 96 +++++++++
 3 files changed

// File: rtl/nac_pkg.sv
// rtl/nac_pkg.sv - shared state encoding and parameter defaults for the coder/host SRAM arbiter
package nac_pkg;
  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CDR_DATA  = 2'd1,
    ST_HOST_DATA = 2'd2
  } nac_state_e;
endpackage

// File: rtl/nac_starve_cnt.sv
// rtl/nac_starve_cnt.sv - saturating host-wait counter with clear and terminal flag
module nac_starve_cnt #(
  parameter int MAX = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);
  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CW'(MAX));
endmodule

// File: rtl/nac_mem_arb.sv
// rtl/nac_mem_arb.sv - single-port SRAM arbiter: coder reads have priority, host gets a forced slot after MAX_WAIT
module nac_mem_arb
  import nac_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cdr_rd_en_i,
  input  logic [ADDR_W-1:0] cdr_addr_i,
  output logic [DATA_W-1:0] cdr_rd_data_o,
  output logic              cdr_stall_o,
  input  logic              table_lock_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic [DATA_W-1:0] host_rd_data_o,
  output logic              host_rd_vld_o,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);
  nac_state_e state_q, state_d;
  logic       host_elig;
  logic       starve_max;

  assign host_elig = host_req_i & (~host_we_i | ~table_lock_i);

  // Outputs are gated by reset so an in-flight read never surfaces while resetting.
  always_comb begin
    state_d        = state_q;
    cdr_stall_o    = cdr_rd_en_i;
    cdr_rd_data_o  = '0;
    host_gnt_o     = 1'b0;
    host_rd_data_o = '0;
    host_rd_vld_o  = 1'b0;
    sram_ce_o      = 1'b0;
    sram_we_o      = 1'b0;
    sram_addr_o    = '0;
    sram_wdata_o   = '0;
    if (!reset_i) begin
      case (state_q)
        ST_IDLE: begin
          if (host_elig && (!cdr_rd_en_i || starve_max)) begin
            host_gnt_o  = 1'b1;
            sram_ce_o   = 1'b1;
            sram_we_o   = host_we_i;
            sram_addr_o = host_addr_i;
            if (host_we_i) begin
              sram_wdata_o = host_wdata_i;
            end else begin
              state_d = ST_HOST_DATA;
            end
          end else if (cdr_rd_en_i) begin
            sram_ce_o   = 1'b1;
            sram_addr_o = cdr_addr_i;
            state_d     = ST_CDR_DATA;
          end
        end
        ST_CDR_DATA: begin
          cdr_rd_data_o = sram_rdata_i;
          cdr_stall_o   = 1'b0;
          state_d       = ST_IDLE;
        end
        ST_HOST_DATA: begin
          host_rd_data_o = sram_rdata_i;
          host_rd_vld_o  = 1'b1;
          state_d        = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  nac_starve_cnt #(.MAX(MAX_WAIT)) u_starve (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .inc_i    (host_elig & ~host_gnt_o),
    .clr_i    (~host_elig | host_gnt_o),
    .at_max_o (starve_max)
  );
endmodule
